// File: rtl/fifo_axis2native_adapter_pkg.sv
// rtl/fifo_axis2native_adapter_pkg.sv - shared defaults and skid-occupancy helper for the AXIS-to-native write adapter
package fifo_axis2native_adapter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 36;
    localparam int DEFAULT_CNT_WIDTH  = 32;

    // The skid entry empties whenever the output entry can take its beat.
    // It fills only when a beat arrives while the output entry is stuck.
    function automatic logic skid_valid_next(input logic skid_valid,
                                             input logic accept,
                                             input logic out_free);
        if (skid_valid) begin
            return ~out_free;
        end
        return accept & ~out_free;
    endfunction

endpackage

// File: rtl/fifo_axis2native_adapter_skid_buf.sv
// rtl/fifo_axis2native_adapter_skid_buf.sv - two-entry skid buffer with a registered upstream ready
module axis_skid_buf
    import fifo_axis2native_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] in_tdata_i,
    input  logic                  in_tvalid_i,
    output logic                  in_tready_o,
    output logic [DATA_WIDTH-1:0] out_tdata_o,
    output logic                  out_tvalid_o,
    input  logic                  out_tready_i,
    output logic                  skid_valid_o
);

    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  accept, drain, out_free;

    always_comb begin
        accept       = in_tvalid_i & ready_q;
        drain        = out_valid_q & out_tready_i;
        out_free     = ~out_valid_q | drain;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_next(skid_valid_q, accept, out_free);
        // Ready is low whenever skid is occupied, so accept never coincides with a full skid.
        if (skid_valid_q && out_free) begin
            out_data_d  = skid_data_q;
            out_valid_d = 1'b1;
        end else if (accept && out_free) begin
            out_data_d  = in_tdata_i;
            out_valid_d = 1'b1;
        end else if (accept) begin
            skid_data_d = in_tdata_i;
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_tready_o  = ready_q;
    assign out_tdata_o  = out_data_q;
    assign out_tvalid_o = out_valid_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fifo_axis2native_adapter.sv
// rtl/fifo_axis2native_adapter.sv - AXIS slave to native FIFO write port with written-beat counter
module fifo_axis2native_adapter
    import fifo_axis2native_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [DATA_WIDTH-1:0] s_payload,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic [CNT_WIDTH-1:0]  wr_beats,
    output logic                  idle
);

    logic                 out_valid;
    logic                 skid_valid;
    logic [CNT_WIDTH-1:0] wr_beats_q, wr_beats_d;

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i       (s_clk),
        .rst_i       (s_rst),
        .in_tdata_i  (s_payload),
        .in_tvalid_i (s_valid),
        .in_tready_o (s_ready),
        .out_tdata_o (fifo_wr_data),
        .out_tvalid_o(out_valid),
        .out_tready_i(~fifo_full),
        .skid_valid_o(skid_valid)
    );

    assign fifo_wr_en = out_valid & ~fifo_full;
    assign idle       = ~out_valid & ~skid_valid;

    always_comb begin
        wr_beats_d = wr_beats_q;
        if (fifo_wr_en) begin
            wr_beats_d = wr_beats_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            wr_beats_q <= '0;
        end else begin
            wr_beats_q <= wr_beats_d;
        end
    end

    assign wr_beats = wr_beats_q;

endmodule

// File: tb/tb_fifo_axis2native_adapter.sv
// tb/tb_fifo_axis2native_adapter.sv - directed and random self-checking bench for fifo_axis2native_adapter
module tb_fifo_axis2native_adapter;

    localparam int DW = 36;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b1;
    logic [DW-1:0] s_payload = '0;
    logic          s_valid = 1'b0;
    logic          fifo_full = 1'b1;

    logic          s_ready, fifo_wr_en, idle;
    logic [DW-1:0] fifo_wr_data;
    logic [31:0]   wr_beats;

    logic          s_ready_w, fifo_wr_en_w, idle_w;
    logic [DW-1:0] fifo_wr_data_w;
    logic [3:0]    wr_beats_w;

    fifo_axis2native_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .s_payload(s_payload), .s_valid(s_valid),
        .s_ready(s_ready), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .wr_beats(wr_beats), .idle(idle)
    );

    fifo_axis2native_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
        .s_clk(s_clk), .s_rst(s_rst), .s_payload(s_payload), .s_valid(s_valid),
        .s_ready(s_ready_w), .fifo_wr_data(fifo_wr_data_w), .fifo_wr_en(fifo_wr_en_w),
        .fifo_full(fifo_full), .wr_beats(wr_beats_w), .idle(idle_w)
    );

    always #5 s_clk = ~s_clk;

    int            pass_cnt = 0;
    int            fail_cnt = 0;
    int            total = 0;
    int            writes = 0;
    logic [DW-1:0] sb[$];
    logic          acc, wr;
    logic [DW-1:0] wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the falling edge, sample 1ns later, then update the scoreboard
    // with what the coming rising edge will do.
    task automatic cyc(input logic v, input logic [DW-1:0] p, input logic f, input logic r);
        @(negedge s_clk);
        s_valid = v; s_payload = p; fifo_full = f; s_rst = r;
        #1;
        acc = s_valid & s_ready & ~s_rst;
        wr  = fifo_wr_en;
        wd  = fifo_wr_data;
        if (f) chk("wr_en_while_full", {63'd0, wr}, 64'd0);
        if (wr && !r) begin
            if (sb.size() == 0) chk("write_with_empty_scoreboard", 64'd1, 64'd0);
            else chk("wr_data_order", {28'd0, wd}, {28'd0, sb.pop_front()});
            writes++;
        end
        if (acc) sb.push_back(p);
        if (r) begin
            sb.delete();
            writes = 0;
        end else begin
            chk("inflight_le_2", {63'd0, sb.size() <= 2}, 64'd1);
        end
    endtask

    initial begin
        int cycles;
        int accepted;
        logic [DW-1:0] seq;

        // Reset held 3 cycles
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 1);
        chk("reset_s_ready", {63'd0, s_ready}, 64'd0);
        cyc(0, '0, 1, 1);
        chk("reset_s_ready_2", {63'd0, s_ready}, 64'd0);
        cyc(0, '0, 0, 0);
        chk("post_reset_s_ready_low", {63'd0, s_ready}, 64'd0);
        chk("reset_wr_beats", {32'd0, wr_beats}, 64'd0);
        chk("reset_idle", {63'd0, idle}, 64'd1);
        chk("reset_wr_en", {63'd0, fifo_wr_en}, 64'd0);
        cyc(0, '0, 0, 0);
        chk("s_ready_first_edge", {63'd0, s_ready}, 64'd1);

        // Streaming 16 beats back to back
        for (int i = 0; i < 16; i++) begin
            cyc(1, DW'(i), 0, 0);
            chk("stream_s_ready", {63'd0, s_ready}, 64'd1);
            chk("stream_wr_en", {63'd0, wr}, (i == 0) ? 64'd0 : 64'd1);
        end
        cyc(0, '0, 0, 0);
        chk("stream_last_wr_en", {63'd0, wr}, 64'd1);
        chk("stream_last_data", {28'd0, wd}, 64'hF);
        cyc(0, '0, 0, 0);
        chk("stream_drained_wr_en", {63'd0, wr}, 64'd0);
        chk("stream_wr_beats", {32'd0, wr_beats}, 64'd16);
        chk("stream_idle", {63'd0, idle}, 64'd1);
        chk("wrap_small_at_16", {60'd0, wr_beats_w}, 64'd0);

        // Full stall with A, B, C offered
        cyc(1, DW'('hA), 1, 0);
        chk("stall_accept_a", {63'd0, acc}, 64'd1);
        cyc(1, DW'('hB), 1, 0);
        chk("stall_accept_b", {63'd0, acc}, 64'd1);
        cyc(1, DW'('hC), 1, 0);
        chk("stall_s_ready_drop", {63'd0, s_ready}, 64'd0);
        chk("stall_c_not_accepted", {63'd0, acc}, 64'd0);
        chk("stall_inflight", 64'(sb.size()), 64'd2);
        cyc(1, DW'('hC), 1, 0);
        chk("stall_idle_low", {63'd0, idle}, 64'd0);
        cyc(1, DW'('hC), 0, 0);
        chk("release_write_a", {wr, 27'd0, wd}, {1'b1, 27'd0, 36'hA});
        chk("release_s_ready_still_low", {63'd0, s_ready}, 64'd0);
        cyc(1, DW'('hC), 0, 0);
        chk("release_write_b", {wr, 27'd0, wd}, {1'b1, 27'd0, 36'hB});
        chk("release_s_ready_back", {63'd0, s_ready}, 64'd1);
        chk("wrap_small_after_17", {60'd0, wr_beats_w}, 64'd1);
        chk("wr_beats_17", {32'd0, wr_beats}, 64'd17);
        cyc(0, '0, 0, 0);
        chk("release_write_c", {wr, 27'd0, wd}, {1'b1, 27'd0, 36'hC});
        cyc(0, '0, 0, 0);
        chk("after_stall_idle", {63'd0, idle}, 64'd1);

        // Reset while both entries are occupied
        cyc(1, DW'('h100), 1, 0);
        cyc(1, DW'('h101), 1, 0);
        cyc(0, '0, 1, 0);
        chk("mid_both_occupied", {62'd0, idle, s_ready}, 64'd0);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 0, 0);
        chk("mid_reset_idle", {63'd0, idle}, 64'd1);
        chk("mid_reset_no_wr", {63'd0, wr}, 64'd0);
        chk("mid_reset_wr_beats", {32'd0, wr_beats}, 64'd0);
        cyc(1, DW'('h200), 0, 0);
        chk("mid_reset_accept", {63'd0, acc}, 64'd1);
        cyc(0, '0, 0, 0);
        chk("mid_reset_first_write", {wr, 27'd0, wd}, {1'b1, 27'd0, 36'h200});
        cyc(0, '0, 0, 0);

        // Random traffic: 10k accepted beats
        seq = DW'('h1000);
        accepted = 0;
        cycles = 0;
        writes = 0;
        cyc(0, '0, 1, 1);
        while (accepted < 10000 && cycles < 60000) begin
            cyc(1'($urandom_range(0, 1)), seq, ($urandom_range(0, 9) < 3), 0);
            if (acc) begin
                accepted++;
                seq = seq + DW'(1);
            end
            cycles++;
        end
        chk("random_budget", {63'd0, accepted == 10000}, 64'd1);
        for (int k = 0; k < 10 && sb.size() != 0; k++) cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        chk("random_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("random_write_count", 64'(writes), 64'd10000);
        chk("random_wr_beats", {32'd0, wr_beats}, 64'(writes));
        chk("random_idle", {63'd0, idle}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
